// File: rtl/fetch_issue_if.sv
// Fetch/issue bus: instruction-memory handshake, decode issue port and control.
// master = fetch_issue side, slave = memory/decode/environment side.
interface fetch_issue_if #(
  parameter int ADDR_W = 8
);
  logic              oIMEM_REQ;
  logic [ADDR_W-1:0] oIMEM_ADDR;
  logic              iIMEM_ACK;
  logic [11:0]       iIMEM_DATA;
  logic              oENABLE;
  logic [11:0]       oINST;
  logic              iSTALL;
  logic              iREDIRECT;
  logic [ADDR_W-1:0] iREDIRECT_PC;
  logic              oEMPTY;
  logic              oHALTED;

  modport master (
    output oIMEM_REQ, oIMEM_ADDR, oENABLE, oINST, oEMPTY, oHALTED,
    input  iIMEM_ACK, iIMEM_DATA, iSTALL, iREDIRECT, iREDIRECT_PC
  );

  modport slave (
    input  oIMEM_REQ, oIMEM_ADDR, oENABLE, oINST, oEMPTY, oHALTED,
    output iIMEM_ACK, iIMEM_DATA, iSTALL, iREDIRECT, iREDIRECT_PC
  );
endinterface

// File: rtl/fetch_issue.sv
// Front end of the 12-bit core: fetch FSM, prefetch FIFO and paced issue to decode.
// Optional macro FETCH_HALT_EN turns word 12'hFFF into a halt marker.
module fetch_issue #(
  parameter int ADDR_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int ISSUE_GAP  = 4,
  parameter int RESET_PC   = 0
) (
  input  logic          iCLK,
  input  logic          iRST_N,
  fetch_issue_if.master bus
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int GAP_W = (ISSUE_GAP > 1) ? $clog2(ISSUE_GAP) : 1;

  localparam logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(RESET_PC);
  localparam logic [CNT_W-1:0]  DEPTH_C    = CNT_W'(FIFO_DEPTH);
  localparam logic [GAP_W-1:0]  GAP_RELOAD = GAP_W'(ISSUE_GAP - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DRAIN
  } fetch_state_e;

  fetch_state_e      state_q;
  logic              req_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] pc_q;

  logic [11:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic              enable_q;
  logic [11:0]       inst_q, inst_d;
  logic              empty_q;
  logic              halted_q;

  logic [11:0]       head_word;
  logic              ack_seen;
  logic              push;
  logic              issue_ok;
  logic              halt_pop;
  logic              fire;

  always_comb begin
    head_word = fifo_mem[rd_ptr_q];
    ack_seen  = req_q && bus.iIMEM_ACK;
    // Only an ack of a live (non-drained, non-redirected) request lands in the FIFO.
    push      = ack_seen && (state_q == S_WAIT) && !bus.iREDIRECT;
    issue_ok  = (count_q != '0) && (gap_q == '0) && !bus.iSTALL &&
                !bus.iREDIRECT && !halted_q;
`ifdef FETCH_HALT_EN
    halt_pop  = issue_ok && (head_word == 12'hFFF);
`else
    halt_pop  = 1'b0;
`endif
    fire      = issue_ok && !halt_pop;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    gap_d    = gap_q;
    inst_d   = inst_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end

    if (bus.iREDIRECT) begin
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end else begin
      if (issue_ok) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push, issue_ok})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end

    if (fire) begin
      gap_d  = GAP_RELOAD;
      inst_d = head_word;
    end else if (gap_q != '0) begin
      gap_d = gap_q - 1'b1;
    end
  end

  // Fetch FSM: one outstanding request, REQ/ADDR registered and never withdrawn.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q <= S_IDLE;
      req_q   <= 1'b0;
      addr_q  <= RESET_ADDR;
      pc_q    <= RESET_ADDR;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.iREDIRECT) begin
            pc_q <= bus.iREDIRECT_PC;
          end else if ((count_q < DEPTH_C) && !halted_q) begin
            state_q <= S_WAIT;
            req_q   <= 1'b1;
            addr_q  <= pc_q;
          end
        end
        S_WAIT: begin
          if (ack_seen) begin
            state_q <= S_IDLE;
            req_q   <= 1'b0;
            pc_q    <= bus.iREDIRECT ? bus.iREDIRECT_PC : pc_q + 1'b1;
          end else if (bus.iREDIRECT) begin
            state_q <= S_DRAIN;
            pc_q    <= bus.iREDIRECT_PC;
          end
        end
        S_DRAIN: begin
          if (bus.iREDIRECT) begin
            pc_q <= bus.iREDIRECT_PC;
          end
          if (ack_seen) begin
            state_q <= S_IDLE;
            req_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge iCLK) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= bus.iIMEM_DATA;
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      gap_q    <= '0;
      enable_q <= 1'b0;
      inst_q   <= '0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      gap_q    <= gap_d;
      enable_q <= fire;
      inst_q   <= inst_d;
      empty_q  <= (count_d == '0);
    end
  end

`ifdef FETCH_HALT_EN
  // Redirect both clears a halt and blocks the pop, so it always takes priority.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      halted_q <= 1'b0;
    end else if (bus.iREDIRECT) begin
      halted_q <= 1'b0;
    end else if (halt_pop) begin
      halted_q <= 1'b1;
    end
  end
`else
  assign halted_q = 1'b0;
`endif

  assign bus.oIMEM_REQ  = req_q;
  assign bus.oIMEM_ADDR = addr_q;
  assign bus.oENABLE    = enable_q;
  assign bus.oINST      = inst_q;
  assign bus.oEMPTY     = empty_q;
  assign bus.oHALTED    = halted_q;

endmodule
